// File: rtl/median_pkg.sv
// median_pkg: shared loader state type and default image geometry for the median filter
// Contents:
//   loader_state_t  - pixel_loader FSM states (IDLE, LOAD, DRAIN, DONE)
//   IMG_W_DEF       - default pixels per row, shared with the window-scan FSM
//   IMG_H_DEF       - default rows per frame, shared with the window-scan FSM
package median_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_t;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

endpackage

// File: rtl/pixel_counter.sv
// pixel_counter: ADDR_W-bit pixel index counter with clear, enable and terminal-count flag
// Ports:
//   clk   in  : rising-edge clock
//   nres  in  : synchronous active-high reset
//   clr   in  : synchronous clear to 0
//   en    in  : increment by one
//   cnt   out : current pixel index
//   tc    out : high while cnt == N-1
module pixel_counter
    import median_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int N      = IMG_W_DEF * IMG_H_DEF
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    always_ff @(posedge clk) begin
        if (nres || clr) cnt <= '0;
        else if (en)     cnt <= cnt + 1'b1;
    end

    assign tc = cnt == LAST;

endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: writes one raster-order 8-bit frame into image RAM and pulses done at frame end
// Optional feature macro: LOADER_FRAME_CHECK_EN enables in_last framing checks and DRAIN.
// Ports:
//   clk          in  : rising-edge clock
//   nres         in  : synchronous active-high reset
//   start        in  : arm for one frame (sampled in IDLE only)
//   in_valid     in  : upstream pixel valid
//   in_data      in  : pixel value
//   in_last      in  : final pixel of a frame
//   in_ready     out : pixel accepted this cycle when valid (LOAD or DRAIN)
//   ram_wr_en    out : registered RAM write strobe
//   ram_wr_addr  out : registered RAM write address (BASE_ADDR + index, wraps)
//   ram_wr_data  out : registered RAM write data
//   busy         out : high in LOAD or DRAIN
//   done         out : one-cycle pulse at end of frame
//   frame_err    out : sticky framing error, cleared by the next accepted start
module pixel_loader
    import median_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [7:0]        ram_wr_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int N = IMG_W * IMG_H;

    loader_state_t     state, state_nx;
    logic [ADDR_W-1:0] pix_cnt;
    logic              tc, arm, xfer, load_xfer;

    // in_ready comes from the state register only, so it never depends on in_valid
    assign in_ready  = state == LOAD || state == DRAIN;
    assign busy      = in_ready;
    assign done      = state == DONE;
    assign arm       = state == IDLE && start;
    assign xfer      = in_valid && in_ready;
    assign load_xfer = xfer && state == LOAD;

    pixel_counter #(.ADDR_W(ADDR_W), .N(N)) u_cnt (
        .clk  (clk),
        .nres (nres),
        .clr  (arm),
        .en   (load_xfer),
        .cnt  (pix_cnt),
        .tc   (tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? LOAD : IDLE;
            LOAD: begin
`ifdef LOADER_FRAME_CHECK_EN
                // early in_last ends a short frame; a full count without in_last drains the excess
                if (load_xfer && (tc || in_last)) state_nx = (tc && !in_last) ? DRAIN : DONE;
`else
                if (load_xfer && tc) state_nx = DONE;
`endif
            end
            DRAIN: if (xfer && in_last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nres) begin
            state       <= IDLE;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            state     <= state_nx;
            ram_wr_en <= load_xfer;
            if (load_xfer) begin
                ram_wr_addr <= ADDR_W'(BASE_ADDR) + pix_cnt;
                ram_wr_data <= in_data;
            end
        end
    end

`ifdef LOADER_FRAME_CHECK_EN
    // a LOAD transfer is misframed exactly when in_last disagrees with the terminal count
    always_ff @(posedge clk) begin
        if (nres || arm)                      frame_err <= 1'b0;
        else if (load_xfer && (tc ^ in_last)) frame_err <= 1'b1;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: randomized directed-sequence bench for pixel_loader (4x4 base 0, and 4x2 base 0xFFFC)
module tb_pixel_loader;

    localparam int N  = 16;
    localparam int NW = 8;

    logic        clk = 1'b0, nres = 1'b1, start_a = 1'b0, start_w = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        rdy_a, we_a, busy_a, done_a, err_a, rdy_w, we_w, busy_w, done_w, err_w;
    logic [15:0] addr_a, addr_w;
    logic [7:0]  wd_a, wd_w;

    always #5 clk = ~clk;

    pixel_loader #(.IMG_W(4), .IMG_H(4), .ADDR_W(16), .BASE_ADDR(0)) dut (
        .clk(clk), .nres(nres), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_a), .ram_wr_en(we_a), .ram_wr_addr(addr_a),
        .ram_wr_data(wd_a), .busy(busy_a), .done(done_a), .frame_err(err_a)
    );

    pixel_loader #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(16'hFFFC)) dut_w (
        .clk(clk), .nres(nres), .start(start_w), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_w), .ram_wr_en(we_w), .ram_wr_addr(addr_w),
        .ram_wr_data(wd_w), .busy(busy_w), .done(done_w), .frame_err(err_w)
    );

    int checks = 0, failures = 0, cyc = 0;
    int exp_writes = 0, xfer_base = 0;
    logic [7:0] pix[32];

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] oaa[$], oaw[$];
    logic [7:0]  oda[$], odw[$];
    int done_a_cnt = 0, done_a_cyc = 0, wr_a_cyc = 0, done_w_cnt = 0, done_w_cyc = 0, wr_w_cyc = 0;
    int timing_bad = 0, xfers = 0, pend_idx = 0;
    logic pend = 1'b0;

    // a write must appear exactly in the cycle after a transfer whose index lies inside the written range
    always @(negedge clk) begin
        if (we_a) begin oaa.push_back(addr_a); oda.push_back(wd_a); wr_a_cyc = cyc; end
        if (done_a) begin done_a_cnt++; done_a_cyc = cyc; end
        if (we_a !== (pend && (pend_idx - xfer_base) < exp_writes)) timing_bad++;
        pend = in_valid && rdy_a && !nres;
        pend_idx = xfers;
        if (pend) xfers++;
    end

    always @(negedge clk) begin
        if (we_w) begin oaw.push_back(addr_w); odw.push_back(wd_w); wr_w_cyc = cyc; end
        if (done_w) begin done_w_cnt++; done_w_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected writes, accepted pixels and framing error from the frame rules alone
    function automatic void model(input int lastpos, input int n, output int wr, output int acc, output logic err);
`ifdef LOADER_FRAME_CHECK_EN
        if (lastpos < n - 1)       begin wr = lastpos + 1; acc = wr;          err = 1'b1; end
        else if (lastpos == n - 1) begin wr = n;           acc = n;           err = 1'b0; end
        else                       begin wr = n;           acc = lastpos + 1; err = 1'b1; end
`else
        wr = n; acc = n; err = 1'b0;
`endif
    endfunction

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic frame(input bit w, input int npix, input int lastpos, input int mode, input int abort_at);
        int n, sent, idle, k, first, last, wr, acc, ob, db, tb0, obs_n;
        logic err, rdy, aborted;
        logic [15:0] base;
        n = w ? NW : N;
        sent = 0; idle = 0; k = 0; first = -1; last = 0; aborted = 1'b0;
        ob = w ? oaw.size() : oaa.size();
        db = w ? done_w_cnt : done_a_cnt;
        tb0 = timing_bad;
        base = w ? 16'hFFFC : 16'h0000;
        model(lastpos, n, wr, acc, err);
        if (abort_at >= 0) wr = abort_at;
        exp_writes = wr;
        xfer_base = xfers;
        for (int i = 0; i < npix; i++) pix[i] = 8'($urandom_range(0, 255));
        if (w) start_w = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_w = 1'b0;
        chk("ready_rise", w ? rdy_w : rdy_a, 1);
        chk("err_clear", w ? err_w : err_a, 0);
        while (sent < npix && idle < 20 && !aborted) begin
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            in_data = pix[sent];
            in_last = sent == lastpos;
            nres = (sent == abort_at) && in_valid;
            rdy = w ? rdy_w : rdy_a;
            @(posedge clk); #1;
            k++;
            if (nres) begin
                aborted = 1'b1;
                nres = 1'b0;
                chk("rst_outs", {rdy_a, we_a, addr_a, wd_a, busy_a, done_a, err_a}, 0);
            end else if (in_valid && rdy) begin
                if (first < 0) first = cyc;
                last = cyc;
                sent++;
                idle = 0;
            end else if (!rdy) idle++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        obs_n = (w ? oaw.size() : oaa.size()) - ob;
        chk("n_writes", obs_n, wr);
        for (int i = 0; i < wr && i < obs_n; i++) begin
            logic [15:0] ea;
            ea = base + 16'(i);
            chk("wr_addr", w ? oaw[ob + i] : oaa[ob + i], ea);
            chk("wr_data", w ? odw[ob + i] : oda[ob + i], pix[i]);
        end
        if (abort_at < 0) begin
            chk("accepted", sent, acc);
            chk("done_cnt", (w ? done_w_cnt : done_a_cnt) - db, 1);
            chk("done_lat", w ? done_w_cyc : done_a_cyc, last);
            if (wr == acc) chk("done_with_wr", w ? done_w_cyc : done_a_cyc, w ? wr_w_cyc : wr_a_cyc);
            chk("frame_err", w ? err_w : err_a, err);
            chk("busy_end", w ? busy_w : busy_a, 0);
            if (mode == 0) chk("no_bubble", last - first, acc - 1);
        end else begin
            chk("no_done", done_a_cnt - db, 0);
            chk("idle_after_rst", {rdy_a, busy_a}, 0);
        end
        if (!w) chk("wr_timing", timing_bad - tb0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {rdy_a, we_a, addr_a, wd_a, busy_a, done_a, err_a}, 0);
        chk("reset_w", {rdy_w, we_w, addr_w, wd_w, busy_w, done_w, err_w}, 0);
        nres = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frame(1'b0, 16, 15, 0, -1);
        frame(1'b0, 16, 15, 1, -1);
        frame(1'b0, 16, 9, 2, -1);
        frame(1'b0, 19, 18, 0, -1);
        frame(1'b0, 16, 15, 0, 7);
        frame(1'b0, 16, 15, 0, -1);
        frame(1'b1, 8, 7, 0, -1);
        frame(1'b0, 16, 15, 2, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
